// File: rtl/udp_img_pkg.sv
// Shared image-over-UDP packet format: header layout, flag bits and the
// depacketizer FSM state type.
package udp_img_pkg;

    localparam logic [15:0] IMG_MAGIC   = 16'hF05A;
    localparam int unsigned IMG_HDR_LEN = 8;

    // Header byte offsets
    localparam logic [2:0] OFS_MAGIC_HI = 3'd0;
    localparam logic [2:0] OFS_MAGIC_LO = 3'd1;
    localparam logic [2:0] OFS_LINE_HI  = 3'd2;
    localparam logic [2:0] OFS_LINE_LO  = 3'd3;
    localparam logic [2:0] OFS_NPIX_HI  = 3'd4;
    localparam logic [2:0] OFS_NPIX_LO  = 3'd5;
    localparam logic [2:0] OFS_FID      = 3'd6;
    localparam logic [2:0] OFS_FLAGS    = 3'd7;

    // Bit positions inside the flags byte
    localparam logic [2:0] FLG_SOF = 3'd0;
    localparam logic [2:0] FLG_EOF = 3'd1;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StPayload,
        StDrop
    } state_e;

endpackage

// File: rtl/udp_img_hdr_chk.sv
// Header capture register plus combinational validity check (magic, pixel
// count range, UDP length consistency).
module udp_img_hdr_chk
    import udp_img_pkg::*;
#(
    parameter logic [15:0] P_MAGIC   = IMG_MAGIC,
    parameter int unsigned P_HDR_LEN = IMG_HDR_LEN,
    parameter int unsigned P_MAX_PIX = 640
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cap,
    input  logic [2:0]  i_idx,
    input  logic [7:0]  i_data,
    input  logic [15:0] i_len,
    output logic        o_hdr_ok,
    output logic [15:0] o_line,
    output logic [15:0] o_npix,
    output logic [7:0]  o_fid
);

    logic [7:0]  hdr_q [P_HDR_LEN];
    logic [15:0] len_q;
    logic [15:0] magic;
    logic [16:0] exp_len;

    always_ff @(posedge i_clk) begin
        if (i_cap) begin
            hdr_q[i_idx] <= i_data;
        end
    end

    // Payload length is only presented reliably with the first byte
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            len_q <= '0;
        end else if (i_cap && (i_idx == 3'd0)) begin
            len_q <= i_len;
        end
    end

    assign magic   = {hdr_q[OFS_MAGIC_HI], hdr_q[OFS_MAGIC_LO]};
    assign o_line  = {hdr_q[OFS_LINE_HI], hdr_q[OFS_LINE_LO]};
    assign o_npix  = {hdr_q[OFS_NPIX_HI], hdr_q[OFS_NPIX_LO]};
    assign o_fid   = hdr_q[OFS_FID];
    assign exp_len = 17'(P_HDR_LEN) + {o_npix, 1'b0};

    assign o_hdr_ok = (magic == P_MAGIC) && (o_npix != 16'd0) &&
                      (32'(o_npix) <= P_MAX_PIX) && ({1'b0, len_q} == exp_len);

endmodule

// File: rtl/udp_img_depkt.sv
// Receive-side image depacketizer: parses the line header, rebuilds RGB565
// pixels and reports packet status and error counts.
module udp_img_depkt
    import udp_img_pkg::*;
#(
    parameter logic [15:0] P_MAGIC   = IMG_MAGIC,
    parameter int unsigned P_HDR_LEN = IMG_HDR_LEN,
    parameter int unsigned P_MAX_PIX = 640
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_rec_len,
    input  logic [7:0]  i_rec_data,
    input  logic        i_rec_valid,
    input  logic        i_rec_last,
    output logic [15:0] o_pix_data,
    output logic        o_pix_valid,
    output logic        o_pix_sol,
    output logic        o_pix_eol,
    output logic        o_pix_sof,
    output logic [15:0] o_line_num,
    output logic [7:0]  o_frame_id,
    output logic        o_pkt_ok,
    output logic        o_pkt_err,
    output logic        o_line_miss,
    output logic [15:0] o_err_cnt
);

    localparam logic [2:0] HdrLast = 3'(P_HDR_LEN - 1);

    state_e      state_q;
    logic [2:0]  idx_q;
    logic [15:0] npix_q, pix_cnt_q, exp_line_q, line_num_q;
    logic [7:0]  frame_id_q, hi_q;
    logic        odd_q, sof_flag_q;
    logic [15:0] pix_data_q, err_cnt_q;
    logic        pix_valid_q, sol_q, eol_q, sof_q, ok_q, err_q, miss_q;

    logic        cap;
    logic [2:0]  cap_idx;
    logic        hdr_ok;
    logic [15:0] hdr_line, hdr_npix;
    logic [7:0]  hdr_fid;

    assign cap     = i_rec_valid && ((state_q == StIdle) || (state_q == StHdr));
    assign cap_idx = (state_q == StIdle) ? 3'd0 : idx_q;

    udp_img_hdr_chk #(
        .P_MAGIC   (P_MAGIC),
        .P_HDR_LEN (P_HDR_LEN),
        .P_MAX_PIX (P_MAX_PIX)
    ) u_hdr_chk (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_cap    (cap),
        .i_idx    (cap_idx),
        .i_data   (i_rec_data),
        .i_len    (i_rec_len),
        .o_hdr_ok (hdr_ok),
        .o_line   (hdr_line),
        .o_npix   (hdr_npix),
        .o_fid    (hdr_fid)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            npix_q      <= '0;
            pix_cnt_q   <= '0;
            exp_line_q  <= '0;
            line_num_q  <= '0;
            frame_id_q  <= '0;
            hi_q        <= '0;
            odd_q       <= 1'b0;
            sof_flag_q  <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            sol_q       <= 1'b0;
            eol_q       <= 1'b0;
            sof_q       <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            pix_valid_q <= 1'b0;
            sol_q       <= 1'b0;
            eol_q       <= 1'b0;
            sof_q       <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            miss_q      <= 1'b0;
            if (i_rec_valid) begin
                unique case (state_q)
                    StIdle: begin
                        idx_q   <= 3'd1;
                        state_q <= i_rec_last ? StDrop : StHdr;
                    end
                    StHdr: begin
                        idx_q <= idx_q + 3'd1;
                        if (i_rec_last) begin
                            err_q   <= 1'b1;
                            state_q <= StIdle;
                        end else if (idx_q == HdrLast) begin
                            if (hdr_ok) begin
                                state_q    <= StPayload;
                                line_num_q <= hdr_line;
                                frame_id_q <= hdr_fid;
                                npix_q     <= hdr_npix;
                                pix_cnt_q  <= '0;
                                odd_q      <= 1'b0;
                                sof_flag_q <= i_rec_data[FLG_SOF];
                                exp_line_q <= hdr_line + 16'd1;
                                miss_q     <= !i_rec_data[FLG_SOF] && (hdr_line != exp_line_q);
                            end else begin
                                state_q <= StDrop;
                            end
                        end
                    end
                    StPayload: begin
                        odd_q <= !odd_q;
                        if (!odd_q) begin
                            hi_q <= i_rec_data;
                            if (i_rec_last) begin
                                err_q   <= 1'b1;
                                state_q <= StIdle;
                            end
                        end else begin
                            pix_data_q  <= {hi_q, i_rec_data};
                            pix_valid_q <= 1'b1;
                            sol_q       <= (pix_cnt_q == 16'd0);
                            sof_q       <= (pix_cnt_q == 16'd0) && sof_flag_q;
                            pix_cnt_q   <= pix_cnt_q + 16'd1;
                            if (pix_cnt_q == npix_q - 16'd1) begin
                                if (i_rec_last) begin
                                    eol_q   <= 1'b1;
                                    ok_q    <= 1'b1;
                                    state_q <= StIdle;
                                end else begin
                                    // Surplus bytes beyond the declared line
                                    state_q <= StDrop;
                                end
                            end else if (i_rec_last) begin
                                err_q   <= 1'b1;
                                state_q <= StIdle;
                            end
                        end
                    end
                    StDrop: begin
                        if (i_rec_last) begin
                            err_q   <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_cnt_q <= '0;
        end else if (err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign o_pix_data  = pix_data_q;
    assign o_pix_valid = pix_valid_q;
    assign o_pix_sol   = sol_q;
    assign o_pix_eol   = eol_q;
    assign o_pix_sof   = sof_q;
    assign o_line_num  = line_num_q;
    assign o_frame_id  = frame_id_q;
    assign o_pkt_ok    = ok_q;
    assign o_pkt_err   = err_q;
    assign o_line_miss = miss_q;
    assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_udp_img_depkt.sv
// Bench for udp_img_depkt: table of packets with expected outcomes, a pixel
// scoreboard, and hand-written reset sequences.
module tb_udp_img_depkt;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rec_len;
    logic [7:0]  rec_data;
    logic        rec_valid, rec_last;
    logic [15:0] pix_data, line_num, err_cnt;
    logic        pix_valid, pix_sol, pix_eol, pix_sof;
    logic [7:0]  frame_id;
    logic        pkt_ok, pkt_err, line_miss;

    always #4 clk = ~clk;

    udp_img_depkt dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rec_len   (rec_len),
        .i_rec_data  (rec_data),
        .i_rec_valid (rec_valid),
        .i_rec_last  (rec_last),
        .o_pix_data  (pix_data),
        .o_pix_valid (pix_valid),
        .o_pix_sol   (pix_sol),
        .o_pix_eol   (pix_eol),
        .o_pix_sof   (pix_sof),
        .o_line_num  (line_num),
        .o_frame_id  (frame_id),
        .o_pkt_ok    (pkt_ok),
        .o_pkt_err   (pkt_err),
        .o_line_miss (line_miss),
        .o_err_cnt   (err_cnt)
    );

    typedef struct {
        logic [15:0] magic, line, npix, len, base;
        logic [7:0]  fid, flags;
        int          nbytes, gap;
        bit          bgap, last_en;
        int          exp_pix;
        bit          exp_ok, exp_err, exp_miss, hdr_ok, chk;
    } vec_t;

    typedef struct packed {
        logic [15:0] data;
        logic        sol, sof, eol;
    } pix_t;

    pix_t exp_q[$];
    vec_t vecs[13];

    int n_checks = 0, n_pass = 0;
    int n_ok = 0, n_err = 0, n_miss = 0;
    int exp_ok_n = 0, exp_err_n = 0, exp_miss_n = 0, exp_errcnt = 0;
    logic [15:0] exp_line = '0;
    logic [7:0]  exp_fid = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic vec_t mk(input logic [15:0] magic, line, npix, len, input logic [7:0] fid,
                                flags, input int nbytes, gap, input bit bgap,
                                input logic [15:0] base, input int exp_pix,
                                input bit ok, err, miss, hdr, chk);
        vec_t v;
        v.magic = magic; v.line = line; v.npix = npix; v.len = len; v.fid = fid;
        v.flags = flags; v.nbytes = nbytes; v.gap = gap; v.bgap = bgap; v.base = base;
        v.last_en = 1'b1; v.exp_pix = exp_pix; v.exp_ok = ok; v.exp_err = err;
        v.exp_miss = miss; v.hdr_ok = hdr; v.chk = chk;
        return v;
    endfunction

    function automatic logic [7:0] pkt_byte(input vec_t v, input int idx);
        logic [15:0] p;
        p = v.base + 16'((idx - 8) / 2) * 16'h4444;
        case (idx)
            0: return v.magic[15:8];
            1: return v.magic[7:0];
            2: return v.line[15:8];
            3: return v.line[7:0];
            4: return v.npix[15:8];
            5: return v.npix[7:0];
            6: return v.fid;
            7: return v.flags;
            default: return (idx % 2 == 0) ? p[15:8] : p[7:0];
        endcase
    endfunction

    task automatic send(input vec_t v);
        pix_t p;
        for (int g = 0; g < v.gap; g++) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < v.exp_pix; k++) begin
            p.data = v.base + 16'(k) * 16'h4444;
            p.sol  = (k == 0);
            p.sof  = (k == 0) && v.flags[0];
            p.eol  = (k == int'(v.npix) - 1) && v.exp_ok;
            exp_q.push_back(p);
        end
        exp_ok_n   += int'(v.exp_ok);
        exp_err_n  += int'(v.exp_err);
        exp_miss_n += int'(v.exp_miss);
        exp_errcnt += int'(v.exp_err);
        if (v.hdr_ok) begin
            exp_line = v.line;
            exp_fid  = v.fid;
        end
        for (int i = 0; i < v.nbytes; i++) begin
            rec_valid = 1'b1;
            rec_data  = pkt_byte(v, i);
            rec_len   = v.len;
            rec_last  = v.last_en && (i == v.nbytes - 1);
            @(posedge clk); #1;
            rec_valid = 1'b0;
            rec_last  = 1'b0;
            if (v.bgap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic check_state(input string tag);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_ok_count"}, n_ok, exp_ok_n);
        check({tag, "_err_count"}, n_err, exp_err_n);
        check({tag, "_miss_count"}, n_miss, exp_miss_n);
        check({tag, "_pix_left"}, exp_q.size(), 0);
        check({tag, "_err_cnt"}, err_cnt, exp_errcnt);
        check({tag, "_line_num"}, line_num, exp_line);
        check({tag, "_frame_id"}, frame_id, exp_fid);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pix_valid"}, {pix_valid, pix_sol, pix_sof, pix_eol}, 4'b0);
        check({tag, "_pulses"}, {pkt_ok, pkt_err, line_miss}, 3'b0);
        check({tag, "_pix_data"}, pix_data, 16'h0);
        check({tag, "_line_num"}, line_num, 16'h0);
        check({tag, "_frame_id"}, frame_id, 8'h0);
        check({tag, "_err_cnt"}, err_cnt, 16'h0);
    endtask

    // Scoreboard and status-pulse monitor
    always @(negedge clk) begin
        pix_t e;
        if (pix_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL pix_extra: got pixel %0h expected none", pix_data);
            end else begin
                e = exp_q.pop_front();
                check("pix_data", pix_data, e.data);
                check("pix_flags", {pix_sol, pix_sof, pix_eol}, {e.sol, e.sof, e.eol});
            end
        end
        if (pkt_ok) begin
            n_ok++;
            check("ok_with_eol", {pix_valid, pix_eol}, 2'b11);
        end
        if (pkt_err) n_err++;
        if (line_miss) n_miss++;
    end

    initial begin
        vec_t v;
        //            magic     line   npix    len     fid    flg  nb   gap bg base  px ok er ms hd ck
        vecs[0]  = mk(16'hF05A, 16'd5, 16'd4, 16'd16, 8'h11, 8'h01, 16, 2, 0, 16'h1234, 4, 1, 0, 0, 1, 1);
        vecs[1]  = mk(16'hF05B, 16'd9, 16'd4, 16'd16, 8'h12, 8'h00, 16, 1, 0, 16'h1234, 0, 0, 1, 0, 0, 1);
        vecs[2]  = mk(16'hF05A, 16'd9, 16'd4, 16'd18, 8'h13, 8'h00, 18, 1, 0, 16'h1234, 0, 0, 1, 0, 0, 1);
        vecs[3]  = mk(16'hF05A, 16'd6, 16'd4, 16'd16, 8'h22, 8'h00, 12, 1, 0, 16'h2000, 2, 0, 1, 0, 1, 0);
        vecs[4]  = mk(16'hF05A, 16'd7, 16'd2, 16'd12, 8'h23, 8'h00, 12, 0, 0, 16'hA5A5, 2, 1, 0, 0, 1, 1);
        vecs[5]  = mk(16'hF05A, 16'd0, 16'd3, 16'd14, 8'h30, 8'h01, 14, 1, 0, 16'h0F0F, 3, 1, 0, 0, 1, 1);
        vecs[6]  = mk(16'hF05A, 16'd1, 16'd1, 16'd10, 8'h30, 8'h00, 10, 1, 0, 16'h7777, 1, 1, 0, 0, 1, 1);
        vecs[7]  = mk(16'hF05A, 16'd3, 16'd2, 16'd12, 8'h30, 8'h00, 12, 1, 0, 16'h4321, 2, 1, 0, 1, 1, 1);
        vecs[8]  = mk(16'hF05A, 16'd9, 16'd0, 16'd8, 8'h40, 8'h00, 10, 1, 0, 16'h0000, 0, 0, 1, 0, 0, 1);
        vecs[9]  = mk(16'hF05A, 16'd9, 16'd641, 16'd1290, 8'h41, 8'h00, 10, 1, 0, 16'h0, 0, 0, 1, 0, 0, 1);
        vecs[10] = mk(16'hF05A, 16'd4, 16'd640, 16'd1288, 8'h42, 8'h00, 1288, 1, 0, 16'h0100, 640, 1, 0, 0, 1, 1);
        vecs[11] = mk(16'hF05A, 16'd5, 16'd3, 16'd14, 8'h43, 8'h02, 14, 3, 1, 16'hBEEF, 3, 1, 0, 0, 1, 1);
        vecs[12] = mk(16'hF05A, 16'd6, 16'd2, 16'd12, 8'h44, 8'h00, 14, 1, 0, 16'hCAFE, 2, 0, 1, 0, 1, 1);

        rst = 1'b1; rec_valid = 1'b0; rec_last = 1'b0; rec_data = '0; rec_len = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        foreach (vecs[i]) begin
            send(vecs[i]);
            if (vecs[i].chk) check_state($sformatf("vec%0d", i));
        end

        // Reset in the middle of a payload: partial packet lost, no status pulse
        v = mk(16'hF05A, 16'd7, 16'd4, 16'd16, 8'h55, 8'h00, 10, 1, 0, 16'h3333, 1, 0, 0, 0, 1, 0);
        v.last_en = 1'b0;
        send(v);
        rst = 1'b1; rec_valid = 1'b1; rec_data = pkt_byte(v, 10);
        @(posedge clk); #1;
        rec_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("midrst");
        check("midrst_err_pulses", n_err, exp_err_n);
        rst = 1'b0;
        exp_errcnt = 0; exp_line = '0; exp_fid = '0;

        // Line 0 without SOF only passes continuity if the expected line was reset
        send(mk(16'hF05A, 16'd0, 16'd2, 16'd12, 8'h66, 8'h00, 12, 1, 0, 16'h5A5A, 2, 1, 0, 0, 1, 1));
        check_state("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
